// File: rtl/multi_receiver_collector_if.sv
// Frame output bundle of the multi-receiver collector.
// master = collector side (drives the frame), slave = downstream consumer.
interface multi_receiver_collector_if #(
    parameter int NUM_CHANNELS = 8,
    parameter int ITER_WIDTH   = 17,
    parameter int POLY_WIDTH   = 17
);
    logic                               frame_valid;
    logic                               frame_ready;
    logic [NUM_CHANNELS*ITER_WIDTH-1:0] frame_data;
    logic [NUM_CHANNELS-1:0]            frame_mask;
    logic [POLY_WIDTH-1:0]              frame_poly;
    logic                               frame_timeout;

    modport master (
        output frame_valid, frame_data, frame_mask, frame_poly, frame_timeout,
        input  frame_ready
    );

    modport slave (
        input  frame_valid, frame_data, frame_mask, frame_poly, frame_timeout,
        output frame_ready
    );
endinterface

// File: rtl/multi_receiver_collector.sv
// Multi-receiver collector: gathers per-channel iteration events into one
// frame per polynomial, closes on completion / timeout / polynomial change,
// and hands the frame downstream over a valid/ready handshake.
// Optional feature macro: DROP_COUNT_EN (builds the saturating drop counter).
module multi_receiver_collector #(
    parameter int NUM_CHANNELS   = 8,
    parameter int ITER_WIDTH     = 17,
    parameter int POLY_WIDTH     = 17,
    parameter int TIMEOUT_CYCLES = 72000,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                               clk_72MHz,
    input  logic                               reset_n,
    input  logic [NUM_CHANNELS-1:0]            chan_enable,
    input  logic [NUM_CHANNELS-1:0]            iter_valid,
    input  logic [NUM_CHANNELS*ITER_WIDTH-1:0] iter_data,
    input  logic [NUM_CHANNELS*POLY_WIDTH-1:0] iter_poly,
    multi_receiver_collector_if.master         frm,
    output logic                               busy,
    input  logic                               clr_drops,
    output logic [DROP_CNT_WIDTH-1:0]          drop_count
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_e;

    state_e                             state_q, state_d;
    logic [NUM_CHANNELS-1:0]            mask_q, mask_d;
    logic [NUM_CHANNELS*ITER_WIDTH-1:0] data_q, data_d;
    logic [POLY_WIDTH-1:0]              poly_q, poly_d;
    logic [TW-1:0]                      timer_q, timer_d;
    logic                               timeout_q, timeout_d;

    logic [NUM_CHANNELS-1:0] elig, match, mism, newcap;
    logic [POLY_WIDTH-1:0]   first_poly, ref_poly;
    logic                    drop_any;

    // Next-state and frame capture logic
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        data_d     = data_q;
        poly_d     = poly_q;
        timer_d    = timer_q;
        timeout_d  = timeout_q;
        drop_any   = 1'b0;
        newcap     = '0;
        first_poly = '0;
        match      = '0;

        elig = iter_valid & chan_enable;
        // Lowest-index eligible channel sets the tag of a new frame
        for (int i = NUM_CHANNELS - 1; i >= 0; i--)
            if (elig[i]) first_poly = iter_poly[i*POLY_WIDTH +: POLY_WIDTH];
        ref_poly = (state_q == IDLE) ? first_poly : poly_q;
        for (int i = 0; i < NUM_CHANNELS; i++)
            match[i] = elig[i] && (iter_poly[i*POLY_WIDTH +: POLY_WIDTH] == ref_poly);
        mism = elig & ~match;

        case (state_q)
            IDLE: begin
                if (|elig) begin
                    poly_d    = first_poly;
                    mask_d    = match;
                    data_d    = '0;   // slots not captured in this frame read 0
                    for (int i = 0; i < NUM_CHANNELS; i++)
                        if (match[i]) data_d[i*ITER_WIDTH +: ITER_WIDTH] = iter_data[i*ITER_WIDTH +: ITER_WIDTH];
                    timer_d   = TW'(1);
                    timeout_d = 1'b0;
                    drop_any  = |mism;
                    state_d   = ((match & chan_enable) == chan_enable) ? EMIT : COLLECT;
                end
            end
            COLLECT: begin
                newcap = match & ~mask_q;
                for (int i = 0; i < NUM_CHANNELS; i++)
                    if (newcap[i]) data_d[i*ITER_WIDTH +: ITER_WIDTH] = iter_data[i*ITER_WIDTH +: ITER_WIDTH];
                mask_d   = mask_q | newcap;
                // Repeat on a captured channel keeps the first value
                drop_any = (|mism) || (|(match & mask_q));
                if (|mism) begin
                    timeout_d = 1'b1;
                    state_d   = EMIT;
                end else if ((mask_d & chan_enable) == chan_enable) begin
                    timeout_d = 1'b0;
                    state_d   = EMIT;
                end else if (timer_q == TIMER_MAX) begin
                    timeout_d = 1'b1;
                    state_d   = EMIT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            EMIT: begin
                drop_any = |elig;
                if (frm.frame_ready) begin
                    state_d = IDLE;
                    mask_d  = '0;
                    timer_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame state registers
    always_ff @(posedge clk_72MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            data_q    <= '0;
            poly_q    <= '0;
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            data_q    <= data_d;
            poly_q    <= poly_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

    assign frm.frame_valid   = (state_q == EMIT);
    assign frm.frame_data    = data_q;
    assign frm.frame_mask    = mask_q;
    assign frm.frame_poly    = poly_q;
    assign frm.frame_timeout = timeout_q;
    assign busy              = (state_q != IDLE);

`ifdef DROP_COUNT_EN
    logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;

    // Saturating count of cycles with drops; clear beats increment
    always_comb begin
        drop_d = drop_q;
        if (clr_drops)
            drop_d = '0;
        else if (drop_any && (drop_q != '1))
            drop_d = drop_q + 1'b1;
    end

    // Drop counter register
    always_ff @(posedge clk_72MHz or negedge reset_n) begin
        if (!reset_n) drop_q <= '0;
        else          drop_q <= drop_d;
    end

    assign drop_count = drop_q;
`else
    logic unused_ok;
    assign unused_ok  = &{1'b0, drop_any, clr_drops};
    assign drop_count = '0;
`endif
endmodule

// File: tb/tb_multi_receiver_collector.sv
// Scoreboard bench for multi_receiver_collector (N=8, TIMEOUT_CYCLES=16).
module tb_multi_receiver_collector;
    localparam int N  = 8;
    localparam int IW = 17;
    localparam int PW = 17;
`ifdef DROP_COUNT_EN
    localparam bit DC = 1'b1;
`else
    localparam bit DC = 1'b0;
`endif

    typedef struct {
        logic [N-1:0]    mask;
        logic [N*IW-1:0] data;
        logic [PW-1:0]   poly;
        logic            to;
    } frame_t;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    chan_enable = '0;
    logic [N-1:0]    iter_valid = '0;
    logic [N*IW-1:0] iter_data = '0;
    logic [N*PW-1:0] iter_poly = '0;
    logic            busy;
    logic            clr_drops = 1'b0;
    logic [15:0]     drop_count;

    multi_receiver_collector_if #(.NUM_CHANNELS(N), .ITER_WIDTH(IW), .POLY_WIDTH(PW)) frm ();

    multi_receiver_collector #(
        .NUM_CHANNELS(N), .ITER_WIDTH(IW), .POLY_WIDTH(PW),
        .TIMEOUT_CYCLES(16), .DROP_CNT_WIDTH(16)
    ) dut (
        .clk_72MHz(clk), .reset_n(reset_n), .chan_enable(chan_enable),
        .iter_valid(iter_valid), .iter_data(iter_data), .iter_poly(iter_poly),
        .frm(frm), .busy(busy), .clr_drops(clr_drops), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int     errors = 0;
    int     checks = 0;
    int     pops = 0;
    int     exp_drops = 0;
    frame_t q[$];

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [IW-1:0] d, input logic [PW-1:0] p);
        iter_data[ch*IW +: IW] = d;
        iter_poly[ch*PW +: PW] = p;
    endtask

    task automatic add_drop();
        if (DC) exp_drops++;
    endtask

    // Monitor: compare every accepted frame against the head of the queue
    always @(negedge clk) begin
        if (reset_n && frm.frame_valid && frm.frame_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame: got mask %0h expected no frame", frm.frame_mask);
            end else begin
                frame_t e;
                e = q.pop_front();
                chk("frame_mask", 160'(frm.frame_mask), 160'(e.mask));
                chk("frame_data", 160'(frm.frame_data), 160'(e.data));
                chk("frame_poly", 160'(frm.frame_poly), 160'(e.poly));
                chk("frame_timeout", 160'(frm.frame_timeout), 160'(e.to));
                pops++;
            end
        end
    end

    initial begin
        frame_t e;
        int n;
        frm.frame_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", 160'(frm.frame_valid), 160'(0));
        chk("rst_busy", 160'(busy), 160'(0));
        chk("rst_mask", 160'(frm.frame_mask), 160'(0));
        chk("rst_drops", 160'(drop_count), 160'(0));
        reset_n = 1'b1;
        tick();

        // 1: eight channels one per cycle, same poly -> complete frame
        chan_enable = 8'hFF;
        e.mask = 8'hFF; e.poly = 17'h0A5A5; e.to = 1'b0; e.data = '0;
        for (int i = 0; i < N; i++) e.data[i*IW +: IW] = 17'(32'h100 + i);
        q.push_back(e);
        for (int i = 0; i < N; i++) begin
            set_ch(i, 17'(32'h100 + i), 17'h0A5A5);
            iter_valid = 8'(1 << i);
            tick();
            if (i == 6) chk("t1_valid_early", 160'(frm.frame_valid), 160'(0));
            if (i == 7) chk("t1_valid_lat", 160'(frm.frame_valid), 160'(1));
        end
        iter_valid = '0;
        tick(); tick();
        chk("t1_idle", 160'(busy), 160'(0));

        // 2: timeout with enable=0x0F, ch0/ch1 only; ch5 disabled is ignored
        chan_enable = 8'h0F;
        e.mask = 8'h03; e.poly = 17'h00333; e.to = 1'b1; e.data = '0;
        e.data[0*IW +: IW] = 17'h21; e.data[1*IW +: IW] = 17'h22;
        q.push_back(e);
        set_ch(0, 17'h21, 17'h00333); iter_valid = 8'h01; tick();
        set_ch(1, 17'h22, 17'h00333); set_ch(5, 17'h55, 17'h00999);
        iter_valid = 8'h22; tick(); n = 1;
        iter_valid = '0;
        while (!frm.frame_valid && n < 100) begin tick(); n++; end
        chk("t2_timeout_cycles", 160'(n), 160'(16));
        tick(); tick();
        chk("t2_drops", 160'(drop_count), 160'(exp_drops));

        // 3: poly change closes the frame early
        chan_enable = 8'hFF;
        e.mask = 8'h01; e.poly = 17'h00001; e.to = 1'b1; e.data = '0;
        e.data[0*IW +: IW] = 17'h11;
        q.push_back(e);
        set_ch(0, 17'h11, 17'h00001); iter_valid = 8'h01; tick();
        set_ch(1, 17'h12, 17'h00002); iter_valid = 8'h02; tick(); add_drop();
        iter_valid = '0;
        chk("t3_valid", 160'(frm.frame_valid), 160'(1));
        tick(); tick();
        chk("t3_drops", 160'(drop_count), 160'(exp_drops));

        // 4: backpressure for 100 cycles while all channels keep strobing
        clr_drops = 1'b1; tick(); clr_drops = 1'b0; exp_drops = 0;
        chk("t4_clr", 160'(drop_count), 160'(0));
        frm.frame_ready = 1'b0;
        e.mask = 8'hFF; e.poly = 17'h0BEEF; e.to = 1'b0; e.data = '0;
        for (int i = 0; i < N; i++) begin
            e.data[i*IW +: IW] = 17'(32'h200 + i);
            set_ch(i, 17'(32'h200 + i), 17'h0BEEF);
        end
        q.push_back(e);
        iter_valid = 8'hFF; tick();
        chk("t4_valid", 160'(frm.frame_valid), 160'(1));
        for (int c = 0; c < 100; c++) begin
            for (int i = 0; i < N; i++) set_ch(i, 17'(32'h1F000 + c), 17'h0BEEF);
            tick(); add_drop();
            chk("t4_hold", 160'(frm.frame_data), 160'(e.data));
        end
        iter_valid = '0;
        chk("t4_drops", 160'(drop_count), 160'(exp_drops));
        frm.frame_ready = 1'b1;
        tick();
        chk("t4_busy", 160'(busy), 160'(0));
        chk("t4_mask_clr", 160'(frm.frame_mask), 160'(0));
        chk("t4_data_kept", 160'(frm.frame_data), 160'(e.data));

        // 5: reset in the middle of a frame discards it
        set_ch(0, 17'h70, 17'h00777); set_ch(1, 17'h71, 17'h00777); set_ch(2, 17'h72, 17'h00777);
        iter_valid = 8'h07; tick(); iter_valid = '0;
        chk("t5_mask", 160'(frm.frame_mask), 160'(8'h07));
        reset_n = 1'b0; #2;
        exp_drops = 0;
        chk("t5_busy", 160'(busy), 160'(0));
        chk("t5_valid", 160'(frm.frame_valid), 160'(0));
        chk("t5_drops", 160'(drop_count), 160'(0));
        tick(); reset_n = 1'b1; tick();
        e.mask = 8'hFF; e.poly = 17'h00888; e.to = 1'b0; e.data = '0;
        for (int i = 0; i < N; i++) begin
            e.data[i*IW +: IW] = 17'(32'h300 + i);
            set_ch(i, 17'(32'h300 + i), 17'h00888);
        end
        q.push_back(e);
        iter_valid = 8'hFF; tick(); iter_valid = '0;
        tick(); tick();

        // 6: repeat on ch3 keeps the first value
        chan_enable = 8'h18;
        e.mask = 8'h18; e.poly = 17'h00005; e.to = 1'b0; e.data = '0;
        e.data[3*IW +: IW] = 17'h100; e.data[4*IW +: IW] = 17'h44;
        q.push_back(e);
        set_ch(3, 17'h100, 17'h00005); iter_valid = 8'h08; tick();
        set_ch(3, 17'h200, 17'h00005); tick(); add_drop();
        set_ch(4, 17'h44, 17'h00005); iter_valid = 8'h10; tick();
        iter_valid = '0;
        tick(); tick();
        chk("t6_drops", 160'(drop_count), 160'(exp_drops));

        // 7: nothing enabled -> stays idle, no drops
        chan_enable = '0; iter_valid = 8'hFF; tick(); tick(); iter_valid = '0;
        chk("t7_busy", 160'(busy), 160'(0));
        chk("t7_drops", 160'(drop_count), 160'(exp_drops));

        tick(); tick();
        chk("queue_empty", 160'(q.size()), 160'(0));
        chk("frames_seen", 160'(pops), 160'(6));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
